// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmitter with a valid/ready payload interface.
// Frame: start bit (0), DATA_BITS data bits LSB first, optional parity bit,
// and STOP_BITS stop bits (1). Every bit is held for CLKS_PER_BIT clocks.
// All outputs, including the serial line, come straight from registers.
// Optional feature: define UART_TX_PARITY_EN to compile in the parity bit
// (even parity, or odd parity when PARITY_ODD=1).
module uart_tx_engine #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx_data,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  // Reject parameter values outside the supported ranges at elaboration.
  if (DATA_BITS < 5 || DATA_BITS > 9 ||
      CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
    $error("uart_tx_engine: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 stop_idx;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  // Last clock of the current bit period.
  always_comb begin
    bit_end = (baud_cnt == CNT_LAST);
  end

  // Frame sequencer: state, baud counter, bit index, shift register and
  // every registered output are updated together here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      stop_idx   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
      o_tx_data  <= 1'b1;
      o_tx_ready <= 1'b1;
      o_tx_busy  <= 1'b0;
      o_tx_done  <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      case (state)
        IDLE: begin
          o_tx_data  <= 1'b1;
          o_tx_ready <= 1'b1;
          o_tx_busy  <= 1'b0;
          baud_cnt   <= '0;
          bit_idx    <= '0;
          stop_idx   <= 1'b0;
          if (i_tx_valid && o_tx_ready) begin
            shift_reg  <= i_tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^i_tx_data) ^ (PARITY_ODD != 0);
`endif
            state      <= START;
            o_tx_data  <= 1'b0;
            o_tx_ready <= 1'b0;
            o_tx_busy  <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            state     <= DATA;
            o_tx_data <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // The line is loaded one bit ahead: on a boundary it takes
        // shift_reg[1], which becomes shift_reg[0] after the shift.
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state     <= PARITY;
              o_tx_data <= parity_bit;
`else
              state     <= STOP;
              o_tx_data <= 1'b1;
`endif
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
              o_tx_data <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            state     <= STOP;
            o_tx_data <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          o_tx_data <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (stop_idx == STOP_LAST) begin
              state      <= IDLE;
              stop_idx   <= 1'b0;
              o_tx_done  <= 1'b1;
              o_tx_ready <= 1'b1;
              o_tx_busy  <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          baud_cnt   <= '0;
          bit_idx    <= '0;
          stop_idx   <= 1'b0;
          o_tx_data  <= 1'b1;
          o_tx_ready <= 1'b1;
          o_tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed self-checking bench for uart_tx_engine.
// Runs with or without UART_TX_PARITY_EN; expected frames adapt to it.
module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB0 = 10 + P;   // bits per frame, 8 data, 1 stop
  localparam int C0  = 4;
  localparam int N0  = NB0 * C0;
  localparam int NB2 = 8 + P;    // bits per frame, 5 data, 2 stop
  localparam int C2  = 3;

  logic clk;
  logic reset;
  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic v0, v1, v2;
  logic rdy0, tx0, busy0, done0;
  logic rdy1, tx1, busy1, done1;
  logic rdy2, tx2, busy2, done2;

  int tests_run = 0;
  int tests_failed = 0;

  logic cap_line [0:255];
  logic cap_busy [0:255];
  int   cap_done_at;
  logic cap_done_next;
  logic cap_done_rdy;
  logic cap_done_busy;
  logic cap_done_line;

  uart_tx_engine #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .i_tx_data(d0), .i_tx_valid(v0),
    .o_tx_ready(rdy0), .o_tx_data(tx0), .o_tx_busy(busy0), .o_tx_done(done0));

  uart_tx_engine #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(1)) dut1 (
    .clk(clk), .reset(reset), .i_tx_data(d1), .i_tx_valid(v1),
    .o_tx_ready(rdy1), .o_tx_data(tx1), .o_tx_busy(busy1), .o_tx_done(done1));

  uart_tx_engine #(.DATA_BITS(5), .CLKS_PER_BIT(3), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
    .clk(clk), .reset(reset), .i_tx_data(d2), .i_tx_valid(v2),
    .o_tx_ready(rdy2), .o_tx_data(tx2), .o_tx_busy(busy2), .o_tx_done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic sample(input int sel, output logic ln, output logic bs,
                        output logic dn, output logic rd);
    case (sel)
      0:       begin ln = tx0; bs = busy0; dn = done0; rd = rdy0; end
      1:       begin ln = tx1; bs = busy1; dn = done1; rd = rdy1; end
      default: begin ln = tx2; bs = busy2; dn = done2; rd = rdy2; end
    endcase
  endtask

  task automatic start_frame(input int sel, input logic [7:0] data);
    @(negedge clk);
    case (sel)
      0:       begin d0 = data; v0 = 1'b1; end
      1:       begin d1 = data; v1 = 1'b1; end
      default: begin d2 = data[4:0]; v2 = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
  endtask

  // Records the line from the first START cycle (k=0) until done.
  task automatic capture(input int sel, input int maxc);
    logic ln, bs, dn, rd;
    cap_done_at = -1;
    cap_done_next = 1'bx;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      sample(sel, ln, bs, dn, rd);
      cap_line[k] = ln;
      cap_busy[k] = bs;
      if (dn) begin
        cap_done_at = k;
        cap_done_rdy = rd;
        cap_done_busy = bs;
        cap_done_line = ln;
        break;
      end
    end
    if (cap_done_at >= 0) begin
      @(negedge clk);
      sample(sel, ln, bs, dn, rd);
      cap_done_next = dn;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    #1 reset = 1'b0;
    #1;
    tests_run++; if (tx0 !== 1'b1)   begin tests_failed++; $display("FAIL reset_line0: got %b expected 1", tx0); end
    tests_run++; if (rdy0 !== 1'b1)  begin tests_failed++; $display("FAIL reset_ready0: got %b expected 1", rdy0); end
    tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy0: got %b expected 0", busy0); end
    tests_run++; if (done0 !== 1'b0) begin tests_failed++; $display("FAIL reset_done0: got %b expected 0", done0); end
    tests_run++; if (tx2 !== 1'b1)   begin tests_failed++; $display("FAIL reset_line2: got %b expected 1", tx2); end
    tests_run++; if (rdy2 !== 1'b1)  begin tests_failed++; $display("FAIL reset_ready2: got %b expected 1", rdy2); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_frame_a5();
    logic [15:0] exp;
`ifdef UART_TX_PARITY_EN
    exp = {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
`else
    exp = {6'b0, 1'b1, 8'hA5, 1'b0};
`endif
    start_frame(0, 8'hA5);
    capture(0, 100);
    for (int k = 0; k < N0; k++) begin
      tests_run++;
      if (cap_line[k] !== exp[k/C0]) begin
        tests_failed++;
        $display("FAIL a5_line[%0d]: got %b expected %b", k, cap_line[k], exp[k/C0]);
      end
      tests_run++;
      if (cap_busy[k] !== 1'b1) begin
        tests_failed++;
        $display("FAIL a5_busy[%0d]: got %b expected 1", k, cap_busy[k]);
      end
    end
    tests_run++; if (cap_done_at != N0)      begin tests_failed++; $display("FAIL a5_done_at: got %0d expected %0d", cap_done_at, N0); end
    tests_run++; if (cap_done_rdy !== 1'b1)  begin tests_failed++; $display("FAIL a5_done_ready: got %b expected 1", cap_done_rdy); end
    tests_run++; if (cap_done_busy !== 1'b0) begin tests_failed++; $display("FAIL a5_done_busy: got %b expected 0", cap_done_busy); end
    tests_run++; if (cap_done_line !== 1'b1) begin tests_failed++; $display("FAIL a5_done_line: got %b expected 1", cap_done_line); end
    tests_run++; if (cap_done_next !== 1'b0) begin tests_failed++; $display("FAIL a5_done_width: got %b expected 0", cap_done_next); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    // 0xA5 has four ones, 0x07 has three.
    start_frame(1, 8'hA5);
    capture(1, 100);
    for (int k = 36; k < 40; k++) begin
      tests_run++;
      if (cap_line[k] !== 1'b1) begin tests_failed++; $display("FAIL odd_a5_par[%0d]: got %b expected 1", k, cap_line[k]); end
    end
    tests_run++; if (cap_done_at != 44) begin tests_failed++; $display("FAIL odd_a5_done_at: got %0d expected 44", cap_done_at); end
    start_frame(0, 8'h07);
    capture(0, 100);
    for (int k = 36; k < 40; k++) begin
      tests_run++;
      if (cap_line[k] !== 1'b1) begin tests_failed++; $display("FAIL even_07_par[%0d]: got %b expected 1", k, cap_line[k]); end
    end
    start_frame(1, 8'h07);
    capture(1, 100);
    for (int k = 36; k < 40; k++) begin
      tests_run++;
      if (cap_line[k] !== 1'b0) begin tests_failed++; $display("FAIL odd_07_par[%0d]: got %b expected 0", k, cap_line[k]); end
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [15:0] exp1, exp2;
    logic ln [0:255];
    logic bs [0:255];
    logic dn [0:255];
    logic l, b, d, r;
    int ndone;
`ifdef UART_TX_PARITY_EN
    exp1 = {5'b0, 1'b1, 1'b1, 8'h01, 1'b0};
    exp2 = {5'b0, 1'b1, 1'b1, 8'h80, 1'b0};
`else
    exp1 = {6'b0, 1'b1, 8'h01, 1'b0};
    exp2 = {6'b0, 1'b1, 8'h80, 1'b0};
`endif
    for (int k = 0; k < 256; k++) begin ln[k] = 1'bx; bs[k] = 1'bx; dn[k] = 1'b0; end
    @(negedge clk);
    d0 = 8'h01; v0 = 1'b1;
    @(posedge clk);
    #1 d0 = 8'h80;
    ndone = 0;
    for (int k = 0; k < 2 * N0 + 10; k++) begin
      @(negedge clk);
      sample(0, l, b, d, r);
      ln[k] = l; bs[k] = b; dn[k] = d;
      if (k == N0 + 1) v0 = 1'b0;
      if (d) ndone++;
      if (ndone == 2) break;
    end
    v0 = 1'b0;
    tests_run++; if (dn[N0] !== 1'b1)     begin tests_failed++; $display("FAIL b2b_done1: got %b expected 1", dn[N0]); end
    tests_run++; if (ln[N0 + 1] !== 1'b0) begin tests_failed++; $display("FAIL b2b_start_line: got %b expected 0", ln[N0 + 1]); end
    tests_run++; if (bs[N0 + 1] !== 1'b1) begin tests_failed++; $display("FAIL b2b_start_busy: got %b expected 1", bs[N0 + 1]); end
    tests_run++; if (dn[2 * N0 + 1] !== 1'b1) begin tests_failed++; $display("FAIL b2b_done2: got %b expected 1", dn[2 * N0 + 1]); end
    tests_run++; if (ndone != 2)          begin tests_failed++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
    for (int j = 0; j < N0; j++) begin
      tests_run++;
      if (ln[j] !== exp1[j/C0]) begin tests_failed++; $display("FAIL b2b_f1[%0d]: got %b expected %b", j, ln[j], exp1[j/C0]); end
      tests_run++;
      if (ln[N0 + 1 + j] !== exp2[j/C0]) begin tests_failed++; $display("FAIL b2b_f2[%0d]: got %b expected %b", j, ln[N0 + 1 + j], exp2[j/C0]); end
    end
  endtask

  task automatic test_data_change();
    @(negedge clk);
    d0 = 8'h00; v0 = 1'b1;
    @(posedge clk);
    #1 v0 = 1'b0;
    @(posedge clk);
    #1 d0 = 8'hFF;
    capture(0, 100);
    d0 = 8'h00;
    // capture started one cycle late, so index k maps to frame cycle k+1
    for (int k = C0 - 1; k < 9 * C0 - 1; k++) begin
      tests_run++;
      if (cap_line[k] !== 1'b0) begin tests_failed++; $display("FAIL chg_data[%0d]: got %b expected 0", k + 1, cap_line[k]); end
    end
    tests_run++; if (cap_done_at != N0 - 1) begin tests_failed++; $display("FAIL chg_done_at: got %0d expected %0d", cap_done_at + 1, N0); end
  endtask

  task automatic test_ignore_busy();
    logic [15:0] exp;
    logic l, b, d, r;
    int done_at;
`ifdef UART_TX_PARITY_EN
    exp = {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
`else
    exp = {6'b0, 1'b1, 8'h3C, 1'b0};
`endif
    start_frame(0, 8'h3C);
    done_at = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      sample(0, l, b, d, r);
      if (d) begin done_at = k; break; end
      tests_run++;
      if (l !== exp[k/C0]) begin tests_failed++; $display("FAIL busy_line[%0d]: got %b expected %b", k, l, exp[k/C0]); end
      if (k == 10) begin d0 = 8'hFF; v0 = 1'b1; end
      if (k == 12) v0 = 1'b0;
      if (k == 25) begin d0 = 8'h00; v0 = 1'b1; end
      if (k == 27) v0 = 1'b0;
    end
    tests_run++; if (done_at != N0) begin tests_failed++; $display("FAIL busy_done_at: got %0d expected %0d", done_at, N0); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests_run++;
      if (busy0 !== 1'b0 || tx0 !== 1'b1) begin
        tests_failed++;
        $display("FAIL busy_no_queue[%0d]: got busy=%b line=%b expected busy=0 line=1", k, busy0, tx0);
      end
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    start_frame(0, 8'h00);
    for (int k = 0; k < 18; k++) @(negedge clk);
    // now in frame cycle 17: data bit 3, line low
    tests_run++; if (tx0 !== 1'b0) begin tests_failed++; $display("FAIL abort_pre_line: got %b expected 0", tx0); end
    reset = 1'b0;
    #1;
    tests_run++; if (tx0 !== 1'b1)   begin tests_failed++; $display("FAIL abort_line: got %b expected 1", tx0); end
    tests_run++; if (rdy0 !== 1'b1)  begin tests_failed++; $display("FAIL abort_ready: got %b expected 1", rdy0); end
    tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b expected 0", busy0); end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done0 !== 1'b0 || busy0 !== 1'b0) seen++;
    end
    tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_accept_after_reset();
    int got;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    d0 = 8'h55; v0 = 1'b1;
    @(posedge clk);
    #1 v0 = 1'b0;
    tests_run++; if (busy0 !== 1'b1) begin tests_failed++; $display("FAIL rst_accept_busy: got %b expected 1", busy0); end
    tests_run++; if (tx0 !== 1'b0)   begin tests_failed++; $display("FAIL rst_accept_line: got %b expected 0", tx0); end
    tests_run++; if (rdy0 !== 1'b0)  begin tests_failed++; $display("FAIL rst_accept_ready: got %b expected 0", rdy0); end
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done0) begin got = 1; break; end
    end
    tests_run++; if (got != 1) begin tests_failed++; $display("FAIL rst_accept_done: got %0d expected 1", got); end
  endtask

  task automatic test_stop2();
    logic [15:0] exp;
    int stop_start;
`ifdef UART_TX_PARITY_EN
    exp = {7'b0, 2'b11, 1'b1, 5'h1F, 1'b0};
`else
    exp = {8'b0, 2'b11, 5'h1F, 1'b0};
`endif
    start_frame(2, 8'h1F);
    capture(2, 100);
    for (int k = 0; k < NB2 * C2; k++) begin
      tests_run++;
      if (cap_line[k] !== exp[k/C2]) begin tests_failed++; $display("FAIL stop2_line[%0d]: got %b expected %b", k, cap_line[k], exp[k/C2]); end
    end
    stop_start = (6 + P) * C2;
    for (int k = stop_start; k < stop_start + 6; k++) begin
      tests_run++;
      if (cap_busy[k] !== 1'b1) begin tests_failed++; $display("FAIL stop2_busy[%0d]: got %b expected 1", k, cap_busy[k]); end
    end
    tests_run++; if (cap_done_at != NB2 * C2) begin tests_failed++; $display("FAIL stop2_done_at: got %0d expected %0d", cap_done_at, NB2 * C2); end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_data_change();
    test_ignore_busy();
    test_reset_abort();
    test_accept_after_reset();
    test_stop2();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
